// File: rtl/snake_dir_ctrl_if.sv
// snake_dir_ctrl_if: key/tick inputs and direction/game-state outputs of the snake direction controller
interface snake_dir_ctrl_if;
    logic [7:0] key_data;
    logic       move_tick;
    logic       game_over;
    logic [1:0] dir;
    logic       run_en;
    logic       paused;
    logic       restart;
    logic [2:0] q_count;
`ifdef SNAKE_DIR_DBG_EN
    logic [7:0] last_key;
    logic [7:0] drop_cnt;
`endif
    modport master (
        output key_data, move_tick, game_over,
`ifdef SNAKE_DIR_DBG_EN
        input  last_key, drop_cnt,
`endif
        input  dir, run_en, paused, restart, q_count
    );
    modport slave (
        input  key_data, move_tick, game_over,
`ifdef SNAKE_DIR_DBG_EN
        output last_key, drop_cnt,
`endif
        output dir, run_en, paused, restart, q_count
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: key decode, turn queue and game-state FSM; SNAKE_DIR_DBG_EN adds last_key/drop_cnt
module snake_dir_ctrl #(
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [1:0] INIT_DIR    = 2'b01
) (
    input logic clk,
    input logic rst,
    snake_dir_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;
    localparam logic [1:0] LAST = 2'(QUEUE_DEPTH - 1);
    state_t     state, state_n;
    logic [7:0] key_prev, lc;
    logic [1:0] q [4];
    logic [1:0] rp, wp, tail, kdir, ref_dir;
    logic [2:0] cnt;
    logic       acc, is_dir, is_sp, rkey, push, pop;
    assign acc     = bus.key_data != 8'h00 && bus.key_data != key_prev;
    assign lc      = bus.key_data | 8'h20;
    assign is_dir  = acc && (lc == 8'h77 || lc == 8'h64 || lc == 8'h73 || lc == 8'h61);
    assign kdir    = lc == 8'h77 ? 2'b00 : lc == 8'h64 ? 2'b01 : lc == 8'h73 ? 2'b10 : 2'b11;
    assign is_sp   = acc && bus.key_data == 8'h20;
    assign rkey    = acc && lc == 8'h72;
    assign tail    = wp == 2'd0 ? LAST : wp - 2'd1;
    assign ref_dir = cnt != 3'd0 ? q[tail] : bus.dir;
    // opposite directions differ only in bit 1
    assign push    = state == RUN && is_dir && !rkey && cnt != 3'(QUEUE_DEPTH)
                     && kdir != ref_dir && kdir != {~ref_dir[1], ref_dir[0]};
    assign pop     = state == RUN && bus.move_tick && !bus.game_over && !rkey && cnt != 3'd0;
    assign bus.q_count = cnt;
    always_comb begin
        state_n = state;
        if (rkey) state_n = IDLE;
        else if (state == IDLE && is_dir) state_n = RUN;
        else if (state == RUN) state_n = bus.game_over ? OVER : is_sp ? PAUSE : RUN;
        else if (state == PAUSE && is_sp) state_n = RUN;
    end
    always_ff @(posedge clk) begin
        key_prev <= bus.key_data;
        if (rst) begin
            state       <= IDLE;
            bus.dir     <= INIT_DIR;
            bus.run_en  <= 1'b0;
            bus.paused  <= 1'b0;
            bus.restart <= 1'b0;
            key_prev    <= 8'h00;
            rp          <= 2'd0;
            wp          <= 2'd0;
            cnt         <= 3'd0;
        end else begin
            state       <= state_n;
            bus.run_en  <= state_n == RUN;
            bus.paused  <= state_n == PAUSE;
            bus.restart <= rkey;
            if (rkey) begin
                bus.dir <= INIT_DIR;
                rp      <= 2'd0;
                wp      <= 2'd0;
                cnt     <= 3'd0;
            end else begin
                if (state == IDLE && is_dir) bus.dir <= kdir;
                else if (pop) bus.dir <= q[rp];
                if (push) begin
                    q[wp] <= kdir;
                    wp    <= wp == LAST ? 2'd0 : wp + 2'd1;
                end
                if (pop) rp <= rp == LAST ? 2'd0 : rp + 2'd1;
                cnt <= cnt + 3'(push) - 3'(pop);
            end
        end
    end
`ifdef SNAKE_DIR_DBG_EN
    always_ff @(posedge clk) begin
        if (rst || rkey) begin
            bus.last_key <= 8'h00;
            bus.drop_cnt <= 8'h00;
        end else begin
            if (is_dir || is_sp) bus.last_key <= bus.key_data;
            if (state == RUN && is_dir && !push && bus.drop_cnt != 8'hff) bus.drop_cnt <= bus.drop_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb_snake_dir_ctrl: directed vectors with hand-computed expectations for snake_dir_ctrl
module tb_snake_dir_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    snake_dir_ctrl_if bus ();
    snake_dir_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] k, input logic mt = 1'b0, input logic go = 1'b0);
        bus.key_data  = k;
        bus.move_tick = mt;
        bus.game_over = go;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input string tag, input logic [1:0] d, input logic [2:0] qc, input logic r, input logic p);
        chk({tag, ".dir"}, 8'(bus.dir), 8'(d));
        chk({tag, ".q"}, 8'(bus.q_count), 8'(qc));
        chk({tag, ".run"}, 8'(bus.run_en), 8'(r));
        chk({tag, ".pause"}, 8'(bus.paused), 8'(p));
    endtask

    initial begin
        rst = 1'b1;
        cyc(8'h00);
        cyc(8'h00);
        rst = 1'b0;
        st("reset", 2'b01, 3'd0, 1'b0, 1'b0);
        chk("reset.restart", 8'(bus.restart), 8'h0);
        cyc(8'h64);
        st("start", 2'b01, 3'd0, 1'b1, 1'b0);
        repeat (4) cyc(8'h64);
        st("hold", 2'b01, 3'd0, 1'b1, 1'b0);
        cyc(8'h00);
        cyc(8'h73);
        cyc(8'h00);
        cyc(8'h61);
        cyc(8'h00);
        st("q2", 2'b01, 3'd2, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);
        st("pop1", 2'b10, 3'd1, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);
        st("pop2", 2'b11, 3'd0, 1'b1, 1'b0);
        cyc(8'h73);
        cyc(8'h00, 1'b1);
        cyc(8'h44);
        cyc(8'h00, 1'b1);
        st("back_right", 2'b01, 3'd0, 1'b1, 1'b0);
        cyc(8'h41);
        cyc(8'h00);
        st("reversal", 2'b01, 3'd0, 1'b1, 1'b0);
        cyc(8'h77);
        cyc(8'h00);
        cyc(8'h64);
        cyc(8'h00);
        cyc(8'h73);
        cyc(8'h00);
        st("full", 2'b01, 3'd2, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);
        chk("full.pop1", 8'(bus.dir), 8'h0);
        cyc(8'h00, 1'b1);
        st("full.pop2", 2'b01, 3'd0, 1'b1, 1'b0);
        cyc(8'h73);
        cyc(8'h20);
        cyc(8'h00);
        st("pause", 2'b01, 3'd1, 1'b0, 1'b1);
        cyc(8'h73, 1'b1);
        cyc(8'h00, 1'b1);
        st("pause.hold", 2'b01, 3'd1, 1'b0, 1'b1);
        cyc(8'h20);
        cyc(8'h00);
        st("resume", 2'b01, 3'd1, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b1);
        st("over", 2'b01, 3'd1, 1'b0, 1'b0);
        cyc(8'h77, 1'b1);
        cyc(8'h00);
        st("over.ign", 2'b01, 3'd1, 1'b0, 1'b0);
        cyc(8'h72);
        chk("rst_key.pulse", 8'(bus.restart), 8'h1);
        st("rst_key", 2'b01, 3'd0, 1'b0, 1'b0);
        cyc(8'h00);
        chk("rst_key.once", 8'(bus.restart), 8'h0);
        cyc(8'h61);
        st("idle_load", 2'b11, 3'd0, 1'b1, 1'b0);
        cyc(8'h52, 1'b1);
        chk("rst_prio.pulse", 8'(bus.restart), 8'h1);
        st("rst_prio", 2'b01, 3'd0, 1'b0, 1'b0);
        cyc(8'h00);
        cyc(8'h64);
        cyc(8'h00);
        cyc(8'h73, 1'b1);
        st("push_tick", 2'b01, 3'd1, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);
        st("push_tick.pop", 2'b10, 3'd0, 1'b1, 1'b0);
        cyc(8'h61);
        cyc(8'h77, 1'b1);
        st("pushpop", 2'b11, 3'd1, 1'b1, 1'b0);
        cyc(8'h00, 1'b1);
        st("pushpop.pop", 2'b00, 3'd0, 1'b1, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
